// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the parametrised UART transmitter and receiver:
//   - parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN)
//   - the frame FSM state enumeration
//   - a helper that turns the XOR of a word's data bits into the parity bit
// No ports; import with `import uart_pkg::*;`.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Frame phases, in line order. The receiver walks the same phases.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    // Even parity makes the total count of ones even, so the bit equals the
    // XOR of the data bits; odd parity is its inverse. PAR_NONE returns 0 and
    // is never placed on the line.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        if (mode == PAR_ODD) begin
            return ~data_xor;
        end else if (mode == PAR_EVEN) begin
            return data_xor;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with first-word fall-through: o_Data always shows the
// head entry, so a consumer can take it on the same cycle it asserts i_Read.
//
// Parameters
//   WIDTH  data word width
//   DEPTH  number of entries; power of two, >= 2
// Ports
//   i_Clock  rising-edge clock
//   i_Reset  synchronous active-high reset; empties the FIFO
//   i_Write  write strobe; ignored while o_Full
//   i_Read   read (pop) strobe; ignored while o_Empty
//   i_Data   word written when i_Write is accepted
//   o_Data   head word (valid while o_Empty = 0)
//   o_Full   registered full flag
//   o_Empty  registered empty flag
//   o_Count  registered occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Write,
    input  logic                     i_Read,
    input  logic [WIDTH-1:0]         i_Data,
    output logic [WIDTH-1:0]         o_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE_FREE = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic [AW-1:0]    r_Wr_Ptr;
    logic [AW-1:0]    r_Rd_Ptr;
    logic [AW:0]      r_Count;
    logic             r_Full;
    logic             r_Empty;
    logic             w_Do_Write;
    logic             w_Do_Read;

    // A write is dropped when full even if a pop happens on the same edge, so
    // acceptance looks only at the registered full flag.
    assign w_Do_Write = i_Write && !r_Full;
    assign w_Do_Read  = i_Read  && !r_Empty;

    // Storage carries no reset; only the pointers and flags decide validity.
    always_ff @(posedge i_Clock) begin
        if (w_Do_Write) begin
            r_Mem[r_Wr_Ptr] <= i_Data;
        end
    end

    // Pointers wrap naturally. Flags are updated from the current count so
    // they change on the very edge of the write or pop that moves them.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
            r_Full   <= 1'b0;
            r_Empty  <= 1'b1;
        end else begin
            if (w_Do_Write) begin
                r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            end
            if (w_Do_Read) begin
                r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            end
            case ({w_Do_Write, w_Do_Read})
                2'b10: begin
                    r_Count <= r_Count + 1'b1;
                    r_Full  <= (r_Count == ONE_FREE);
                    r_Empty <= 1'b0;
                end
                2'b01: begin
                    r_Count <= r_Count - 1'b1;
                    r_Full  <= 1'b0;
                    r_Empty <= (r_Count == (AW+1)'(1));
                end
                default: begin
                    r_Count <= r_Count;
                end
            endcase
        end
    end

    assign o_Data  = r_Mem[r_Rd_Ptr];
    assign o_Full  = r_Full;
    assign o_Empty = r_Empty;
    assign o_Count = r_Count;

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered, parametrised UART transmitter. Words written into the internal
// FIFO are sent as start + DATA_BITS (LSB first) + optional parity +
// STOP_BITS frames. While the FIFO holds data, frames follow each other with
// no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        PAR_NONE / PAR_ODD / PAR_EVEN
//   STOP_BITS     1 or 2
//   FIFO_DEPTH    FIFO entries; power of two, >= 2
// Ports
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous active-high reset; aborts any frame, empties FIFO
//   i_TX_DV      write strobe, one entry per high cycle
//   i_TX_Data    word sampled when i_TX_DV = 1
//   o_TX_Serial  serial line, idles high
//   o_TX_Active  high from first start-bit cycle to last stop-bit cycle of a burst
//   o_TX_Done    one-cycle pulse after each frame's final stop bit
//   o_Full       FIFO full
//   o_Empty      FIFO empty
//   o_Count      FIFO occupancy
//   o_Overflow   one-cycle pulse the cycle after a write was dropped
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         i_TX_DV,
    input  logic [DATA_BITS-1:0]         i_TX_Data,
    output logic                         o_TX_Serial,
    output logic                         o_TX_Active,
    output logic                         o_TX_Done,
    output logic                         o_Full,
    output logic                         o_Empty,
    output logic [$clog2(FIFO_DEPTH):0]  o_Count,
    output logic                         o_Overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t           r_State;
    logic [CNT_W-1:0]      r_Clk_Count;
    logic [IDX_W-1:0]      r_Bit_Index;
    logic                  r_Stop_Index;
    logic [DATA_BITS-1:0]  r_TX_Word;
    logic                  r_TX_Serial;
    logic                  r_TX_Active;
    logic                  r_TX_Done;
    logic                  r_Overflow;

    logic [DATA_BITS-1:0]  w_Fifo_Data;
    logic                  w_Full;
    logic                  w_Empty;
    logic                  w_Bit_End;
    logic                  w_Frame_End;
    logic                  w_Pop;
    logic                  w_Parity_Bit;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Write (i_TX_DV),
        .i_Read  (w_Pop),
        .i_Data  (i_TX_Data),
        .o_Data  (w_Fifo_Data),
        .o_Full  (w_Full),
        .o_Empty (w_Empty),
        .o_Count (o_Count)
    );

    // The head word is popped either from idle or on the last cycle of the
    // final stop bit; the latter is what lets the next start bit follow the
    // stop bit directly.
    assign w_Bit_End    = (r_Clk_Count == CNT_LAST);
    assign w_Frame_End  = (r_State == S_STOP) && w_Bit_End && (r_Stop_Index == STOP_LAST);
    assign w_Pop        = !w_Empty && ((r_State == S_IDLE) || w_Frame_End);
    assign w_Parity_Bit = parity_bit(^r_TX_Word, PARITY);

    // Frame FSM. The line value is registered together with the state, so
    // each transition also loads the first level of the phase being entered.
    // r_TX_Word is only loaded on a pop and is held for the entire frame.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State      <= S_IDLE;
            r_Clk_Count  <= '0;
            r_Bit_Index  <= '0;
            r_Stop_Index <= 1'b0;
            r_TX_Word    <= '0;
            r_TX_Serial  <= 1'b1;
            r_TX_Active  <= 1'b0;
            r_TX_Done    <= 1'b0;
        end else begin
            r_TX_Done   <= 1'b0;
            r_Clk_Count <= w_Bit_End ? '0 : r_Clk_Count + 1'b1;

            case (r_State)
                S_IDLE: begin
                    r_Clk_Count <= '0;
                    r_TX_Serial <= 1'b1;
                    r_TX_Active <= 1'b0;
                    if (w_Pop) begin
                        r_TX_Word    <= w_Fifo_Data;
                        r_Bit_Index  <= '0;
                        r_Stop_Index <= 1'b0;
                        r_TX_Serial  <= 1'b0;
                        r_TX_Active  <= 1'b1;
                        r_State      <= S_START;
                    end
                end

                S_START: begin
                    if (w_Bit_End) begin
                        r_Bit_Index <= '0;
                        r_TX_Serial <= r_TX_Word[0];
                        r_State     <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_Bit_End) begin
                        if (r_Bit_Index == IDX_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                r_TX_Serial <= w_Parity_Bit;
                                r_State     <= S_PARITY;
                            end else begin
                                r_Stop_Index <= 1'b0;
                                r_TX_Serial  <= 1'b1;
                                r_State      <= S_STOP;
                            end
                        end else begin
                            r_Bit_Index <= r_Bit_Index + 1'b1;
                            r_TX_Serial <= r_TX_Word[r_Bit_Index + 1'b1];
                        end
                    end
                end

                S_PARITY: begin
                    if (w_Bit_End) begin
                        r_Stop_Index <= 1'b0;
                        r_TX_Serial  <= 1'b1;
                        r_State      <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (w_Bit_End) begin
                        if (r_Stop_Index == STOP_LAST) begin
                            r_TX_Done <= 1'b1;
                            if (w_Pop) begin
                                r_TX_Word    <= w_Fifo_Data;
                                r_Bit_Index  <= '0;
                                r_Stop_Index <= 1'b0;
                                r_TX_Serial  <= 1'b0;
                                r_State      <= S_START;
                            end else begin
                                r_TX_Serial <= 1'b1;
                                r_TX_Active <= 1'b0;
                                r_State     <= S_IDLE;
                            end
                        end else begin
                            r_Stop_Index <= r_Stop_Index + 1'b1;
                        end
                    end
                end

                default: begin
                    r_TX_Serial <= 1'b1;
                    r_TX_Active <= 1'b0;
                    r_State     <= S_IDLE;
                end
            endcase
        end
    end

    // A dropped write is flagged one cycle later; the FIFO's registered full
    // flag is the same condition it uses to refuse the write.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Overflow <= 1'b0;
        end else begin
            r_Overflow <= i_TX_DV && w_Full;
        end
    end

    assign o_TX_Serial = r_TX_Serial;
    assign o_TX_Active = r_TX_Active;
    assign o_TX_Done   = r_TX_Done;
    assign o_Full      = w_Full;
    assign o_Empty     = w_Empty;
    assign o_Overflow  = r_Overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Three transmitter instances at CLKS_PER_BIT = 4:
//   dut 0 : 8E1, depth 16
//   dut 1 : 7O2, depth 16
//   dut 2 : 8N1, depth 4
// Accepted words are pushed to a per-instance scoreboard when written; a
// frame decoder pops them when the line shows a start bit and compares every
// cycle of every bit against the frame built from the popped word.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    typedef struct packed {
        logic [8:0] data;
        logic       par;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic       expPar;
    } vec_t;

    logic       clock;
    logic [2:0] reset;
    logic [2:0] txDv;
    logic [7:0] dataA;
    logic [6:0] dataB;
    logic [7:0] dataC;
    logic [2:0] serialV;
    logic [2:0] activeV;
    logic [2:0] doneV;
    logic [2:0] fullV;
    logic [2:0] emptyV;
    logic [2:0] overflowV;
    logic [4:0] countA;
    logic [4:0] countB;
    logic [2:0] countC;

    int cfgBits [3] = '{8, 7, 8};
    int cfgPar  [3] = '{2, 1, 0};
    int cfgStop [3] = '{1, 2, 1};

    frame_t sbA[$];
    frame_t sbB[$];
    frame_t sbC[$];

    int total = 0;
    int bad   = 0;

    int doneCnt [3] = '{0, 0, 0};
    int cycleNum  = 0;
    int runC      = 0;
    int lastRunC  = 0;
    int lastDoneC = -1;
    int gapsC[$];

    vec_t vecs [7];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (16)
    ) dutA (
        .i_Clock (clock), .i_Reset (reset[0]), .i_TX_DV (txDv[0]), .i_TX_Data (dataA),
        .o_TX_Serial (serialV[0]), .o_TX_Active (activeV[0]), .o_TX_Done (doneV[0]),
        .o_Full (fullV[0]), .o_Empty (emptyV[0]), .o_Count (countA), .o_Overflow (overflowV[0])
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (7), .PARITY (1), .STOP_BITS (2), .FIFO_DEPTH (16)
    ) dutB (
        .i_Clock (clock), .i_Reset (reset[1]), .i_TX_DV (txDv[1]), .i_TX_Data (dataB),
        .o_TX_Serial (serialV[1]), .o_TX_Active (activeV[1]), .o_TX_Done (doneV[1]),
        .o_Full (fullV[1]), .o_Empty (emptyV[1]), .o_Count (countB), .o_Overflow (overflowV[1])
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) dutC (
        .i_Clock (clock), .i_Reset (reset[2]), .i_TX_DV (txDv[2]), .i_TX_Data (dataC),
        .o_TX_Serial (serialV[2]), .o_TX_Active (activeV[2]), .o_TX_Done (doneV[2]),
        .o_Full (fullV[2]), .o_Empty (emptyV[2]), .o_Count (countC), .o_Overflow (overflowV[2])
    );

    // Background monitor: done pulses per instance, plus burst length and
    // done-to-done spacing on the 8N1 instance.
    always @(negedge clock) begin
        cycleNum++;
        for (int i = 0; i < 3; i++) begin
            if (doneV[i] === 1'b1) doneCnt[i]++;
        end
        if (activeV[2] === 1'b1) begin
            runC++;
        end else begin
            if (runC > 0) lastRunC = runC;
            runC = 0;
        end
        if (doneV[2] === 1'b1) begin
            if (lastDoneC >= 0) gapsC.push_back(cycleNum - lastDoneC);
            lastDoneC = cycleNum;
        end
    end

    // Never let the run hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int getCount(input int idx);
        case (idx)
            0:       return int'(countA);
            1:       return int'(countB);
            default: return int'(countC);
        endcase
    endfunction

    function automatic bit popExpected(input int idx, output frame_t f);
        f = '0;
        case (idx)
            0: begin if (sbA.size() == 0) return 1'b0; f = sbA.pop_front(); end
            1: begin if (sbB.size() == 0) return 1'b0; f = sbB.pop_front(); end
            default: begin if (sbC.size() == 0) return 1'b0; f = sbC.pop_front(); end
        endcase
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one write for the next edge, records it on the scoreboard if the
    // FIFO is expected to accept it, and returns on the following negedge
    // with the strobe still high.
    task automatic applyStimulus(input int idx, input logic [8:0] word, input logic par, input bit push);
        frame_t f;
        f.data = word;
        f.par  = par;
        case (idx)
            0: begin txDv[0] = 1'b1; dataA = word[7:0]; if (push) sbA.push_back(f); end
            1: begin txDv[1] = 1'b1; dataB = word[6:0]; if (push) sbB.push_back(f); end
            default: begin txDv[2] = 1'b1; dataC = word[7:0]; if (push) sbC.push_back(f); end
        endcase
        @(negedge clock);
    endtask

    task automatic idleInputs();
        txDv = '0;
    endtask

    // Waits for a start bit, then checks each bit period cycle by cycle
    // against the frame built from the next scoreboard entry, and finally
    // the done pulse on the cycle after the last stop bit.
    task automatic captureFrame(input int idx);
        frame_t f;
        logic   bits [16];
        logic   got;
        int     n;
        int     budget;
        budget = 0;
        while (serialV[idx] !== 1'b0 && budget < 3000) begin
            @(negedge clock);
            budget++;
        end
        if (serialV[idx] !== 1'b0) begin
            checkOutput($sformatf("dut%0d start bit within budget", idx), 32'(serialV[idx]), 32'd0);
            return;
        end
        if (!popExpected(idx, f)) begin
            checkOutput($sformatf("dut%0d frame expected by scoreboard", idx), 32'd1, 32'd0);
            return;
        end
        n = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < cfgBits[idx]; i++) begin
            bits[n] = f.data[i];
            n++;
        end
        if (cfgPar[idx] != 0) begin
            bits[n] = f.par;
            n++;
        end
        for (int i = 0; i < cfgStop[idx]; i++) begin
            bits[n] = 1'b1;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            got = bits[b];
            for (int c = 0; c < CPB; c++) begin
                if (serialV[idx] !== bits[b]) got = serialV[idx];
                @(negedge clock);
            end
            checkOutput($sformatf("dut%0d word %0h bit %0d", idx, f.data, b), 32'(got), 32'(bits[b]));
        end
        checkOutput($sformatf("dut%0d word %0h done pulse", idx, f.data), 32'(doneV[idx]), 32'd1);
    endtask

    // One word written into an idle transmitter: pop latency, the frame, and
    // a single done pulse.
    task automatic runFrame(input int idx, input logic [8:0] word, input logic par);
        int d0;
        d0 = doneCnt[idx];
        fork
            begin
                applyStimulus(idx, word, par, 1'b1);
                idleInputs();
                checkOutput($sformatf("dut%0d empty after write", idx), 32'(emptyV[idx]), 32'd0);
                checkOutput($sformatf("dut%0d count after write", idx), 32'(getCount(idx)), 32'd1);
                checkOutput($sformatf("dut%0d line before pop", idx), 32'(serialV[idx]), 32'd1);
                @(negedge clock);
                checkOutput($sformatf("dut%0d start on pop", idx), 32'(serialV[idx]), 32'd0);
                checkOutput($sformatf("dut%0d active on pop", idx), 32'(activeV[idx]), 32'd1);
                checkOutput($sformatf("dut%0d empty after pop", idx), 32'(emptyV[idx]), 32'd1);
            end
            captureFrame(idx);
        join
        checkOutput($sformatf("dut%0d active after done", idx), 32'(activeV[idx]), 32'd0);
        repeat (2) @(negedge clock);
        checkOutput($sformatf("dut%0d done pulses", idx), 32'(doneCnt[idx] - d0), 32'd1);
    endtask

    initial begin
        int  d0;
        bit  sawLow;
        bit  sawActive;

        vecs[0] = '{8'h3F, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'h01, 1'b1};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'hA7, 1'b1};
        vecs[6] = '{8'h96, 1'b0};

        txDv  = '0;
        dataA = '0;
        dataB = '0;
        dataC = '0;
        reset = 3'b111;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("dut%0d reset serial", i),   32'(serialV[i]),   32'd1);
            checkOutput($sformatf("dut%0d reset active", i),   32'(activeV[i]),   32'd0);
            checkOutput($sformatf("dut%0d reset done", i),     32'(doneV[i]),     32'd0);
            checkOutput($sformatf("dut%0d reset full", i),     32'(fullV[i]),     32'd0);
            checkOutput($sformatf("dut%0d reset empty", i),    32'(emptyV[i]),    32'd1);
            checkOutput($sformatf("dut%0d reset count", i),    32'(getCount(i)),  32'd0);
            checkOutput($sformatf("dut%0d reset overflow", i), 32'(overflowV[i]), 32'd0);
        end
        reset = '0;
        repeat (2) @(negedge clock);

        $display("[TB] 8E1 table");
        for (int v = 0; v < 7; v++) begin
            runFrame(0, {1'b0, vecs[v].data}, vecs[v].expPar);
            repeat (3) @(negedge clock);
        end

        $display("[TB] 7O2 single word");
        runFrame(1, 9'h055, 1'b1);
        repeat (3) @(negedge clock);

        $display("[TB] 8N1 back-to-back");
        fork
            begin
                applyStimulus(2, 9'h0A5, 1'b0, 1'b1);
                applyStimulus(2, 9'h05A, 1'b0, 1'b1);
                applyStimulus(2, 9'h0FF, 1'b0, 1'b1);
                idleInputs();
            end
            begin
                repeat (3) captureFrame(2);
            end
        join
        repeat (3) @(negedge clock);
        checkOutput("burst active length", 32'(lastRunC), 32'd120);
        checkOutput("burst done count", 32'(gapsC.size()), 32'd2);
        if (gapsC.size() == 2) begin
            checkOutput("done gap 1", 32'(gapsC[0]), 32'd40);
            checkOutput("done gap 2", 32'(gapsC[1]), 32'd40);
        end

        $display("[TB] overflow with depth 4");
        fork
            begin
                applyStimulus(2, 9'h011, 1'b0, 1'b1);
                idleInputs();
                repeat (2) @(negedge clock);
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(2, 9'(8'hC0 + i), 1'b0, i < 4);
                    checkOutput($sformatf("overflow after write %0d", i), 32'(overflowV[2]), 32'(i >= 4));
                    checkOutput($sformatf("full after write %0d", i),     32'(fullV[2]),     32'(i >= 3));
                    checkOutput($sformatf("count after write %0d", i),    32'(countC),       32'((i < 4) ? i + 1 : 4));
                end
                idleInputs();
                @(negedge clock);
                checkOutput("overflow clears", 32'(overflowV[2]), 32'd0);
            end
            begin
                repeat (5) captureFrame(2);
            end
        join
        repeat (2) @(negedge clock);
        checkOutput("empty after drain", 32'(emptyV[2]), 32'd1);
        checkOutput("scoreboard C drained", 32'(sbC.size()), 32'd0);

        $display("[TB] reset mid-frame");
        d0 = doneCnt[2];
        applyStimulus(2, 9'h0F7, 1'b0, 1'b0);
        applyStimulus(2, 9'h012, 1'b0, 1'b0);
        applyStimulus(2, 9'h034, 1'b0, 1'b0);
        idleInputs();
        checkOutput("queued before reset", 32'(countC), 32'd2);
        repeat (16) @(negedge clock);
        checkOutput("data bit 3 before reset", 32'(serialV[2]), 32'd0);
        reset[2] = 1'b1;
        @(negedge clock);
        reset[2] = 1'b0;
        checkOutput("serial after reset", 32'(serialV[2]), 32'd1);
        checkOutput("active after reset", 32'(activeV[2]), 32'd0);
        checkOutput("count after reset",  32'(countC),     32'd0);
        checkOutput("empty after reset",  32'(emptyV[2]),  32'd1);
        sawLow    = 1'b0;
        sawActive = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (serialV[2] !== 1'b1) sawLow = 1'b1;
            if (activeV[2] !== 1'b0) sawActive = 1'b1;
        end
        checkOutput("line quiet after reset",   32'(sawLow),    32'd0);
        checkOutput("active quiet after reset", 32'(sawActive), 32'd0);
        checkOutput("no done for aborted frame", 32'(doneCnt[2] - d0), 32'd0);

        checkOutput("scoreboard A drained", 32'(sbA.size()), 32'd0);
        checkOutput("scoreboard B drained", 32'(sbB.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
